ascon_aead_seq: RTL and testbench
=================================

// Module: ascon_aead_seq
// PURPOSE
// Parametrised AEAD sequencer driving one ascon core over its strobe interface: init, AD absorb, PT encrypt, finalise, tag.
// Message and AD lengths are runtime-selectable up to compile-time maxima.
// Adds start/busy/done handshake, optional tag check, per-step watchdog and error reporting.
// Sits between the system bus registers and the ascon core; the core is external, so it can be bench-modelled.
// PARAMETERS
// MAX_PT_BLOCKS  23    max 64-bit plaintext blocks per message (>=1)
// MAX_AD_BLOCKS  4     max 64-bit AD blocks per message (>=1)
// TIMEOUT_CYC    1024  max cycles waited for any core response before error
// PORTS
// clock_i          in   1                  clock, all logic on rising edge
// reset_i          in   1                  asynchronous active-low reset
// start_i          in   1                  start request, sampled only in IDLE
// pt_len_i         in   $clog2(MAX_PT_BLOCKS+1)  PT block count, valid 1..MAX_PT_BLOCKS
// ad_len_i         in   $clog2(MAX_AD_BLOCKS+1)  AD block count, 0..MAX_AD_BLOCKS
// check_tag_i      in   1                  1: compare tag against exp_tag_i
// plain_text_i     in   64*MAX_PT_BLOCKS   block k at [64k+:64]
// ad_i             in   64*MAX_AD_BLOCKS   block k at [64k+:64]
// key_i / nonce_i  in   128 / 128          captured at start
// exp_tag_i        in   128                expected tag
// busy_o           out  1                  high from accepted start until done_o
// done_o           out  1                  one-cycle completion pulse
// error_o          out  2                  0 ok, 1 bad length, 2 timeout, 3 tag mismatch; held until next start
// cipher_o         out  64*MAX_PT_BLOCKS   ciphertext, same packing, unused blocks 0
// tag_o            out  128                captured tag
// core_init_o, core_ad_o, core_final_o, core_valid_o  out  1  core strobes
// core_data_o      out  64                 core data
// core_key_o/core_nonce_o  out  128        registered key/nonce
// core_end_init_i, core_end_ad_i, core_cipher_valid_i, core_end_cipher_i, core_end_tag_i  in  1  core status
// core_cipher_i / core_tag_i  in  64 / 128  core results
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0, including cipher_o, tag_o, error_o, counters.
// - All outputs are registered, so strobes appear the cycle after the state entry decision.
// - IDLE, start_i=1, pt_len_i in range, ad_len_i in range:
//   - latch lengths, key and nonce; clear cipher_o, tag_o and error_o;
//   - busy_o=1; go to INIT.
// - IDLE, start_i=1, length out of range: error_o=1, done_o pulses, busy_o stays 0, no core strobe.
// - INIT: core_init_o one cycle -> WAIT_INIT until core_end_init_i.
//   - Then go to AD_LOAD if ad_len>0, else PT_LOAD.
// - AD_LOAD: core_ad_o=core_valid_o=1 one cycle, core_data_o=ad block cnt -> AD_WAIT.
//   - On core_end_ad_i: cnt++; if cnt==ad_len go to PT_LOAD with cnt=0, else AD_LOAD.
// - PT_LOAD: core_valid_o one cycle with PT block cnt.
//   - If cnt==pt_len-1, core_final_o=1 and go to FINAL_WAIT, else PT_WAIT.
// - PT_WAIT: core_cipher_valid_i writes core_cipher_i to cipher_o block cnt.
//   - On core_end_cipher_i: cnt++, go to PT_LOAD.
// - FINAL_WAIT: capture cipher block as in PT_WAIT.
//   - On core_end_tag_i: tag_o<=core_tag_i, go to DONE.
// - DONE: done_o=1, busy_o=0; if check_tag_i && tag!=exp_tag_i, error_o=3 -> IDLE.
// - Cipher valid and end in the same cycle: the capture still happens before cnt advances.
// - Strobes are never repeated while waiting; start_i is ignored while busy.
// - Watchdog: cleared on each state change; in any *WAIT state, reaching TIMEOUT_CYC gives:
//   - error_o=2, done_o pulse, return to IDLE;
//   - cipher_o and tag_o keep partial contents.
// - Counters never wrap: cnt width is $clog2(MAX+1), and bounds are compared against the latched length.
// - Reset mid-operation: immediate return to IDLE with all outputs 0; the core sees strobes drop.
// TESTING
// - Reset, then pt_len=3, ad_len=1 with a 4-cycle-latency core model:
//   - strobe order is init, AD0, PT0, PT1, PT2+final;
//   - cipher_o blocks 0..2 match the model, done_o is one pulse, error_o=0.
// - ad_len=0, pt_len=1: no core_ad_o pulse; first PT block carries core_final_o; tag_o matches.
// - pt_len=0, then pt_len=MAX+1: error_o=1, done_o pulse, no core strobe, busy_o=0.
// - check_tag_i=1 with exp_tag_i = model tag ^ 1: error_o=3; with the correct tag: error_o=0.
// - Model never raises core_end_cipher_i on PT1: error_o=2 after TIMEOUT_CYC cycles, FSM in IDLE.
// - Reset asserted during PT_WAIT: outputs 0 in the same cycle; a following start runs cleanly.

Source files
------------

// File: rtl/ascon_aead_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ascon_aead_seq_if : strobe/status bus between sequencer and core      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface ascon_aead_seq_if;
  logic         init;
  logic         ad;
  logic         fin;
  logic         valid;
  logic [63:0]  data;
  logic [127:0] key;
  logic [127:0] nonce;
  logic         end_init;
  logic         end_ad;
  logic         cipher_valid;
  logic         end_cipher;
  logic         end_tag;
  logic [63:0]  cipher;
  logic [127:0] tag;

  modport master (
    output init, ad, fin, valid, data, key, nonce,
    input  end_init, end_ad, cipher_valid, end_cipher, end_tag, cipher, tag
  );

  modport slave (
    input  init, ad, fin, valid, data, key, nonce,
    output end_init, end_ad, cipher_valid, end_cipher, end_tag, cipher, tag
  );
endinterface
`default_nettype wire

// File: rtl/ascon_aead_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ascon_aead_seq : AEAD sequencer (init, AD, PT, final, tag) for one   |
// | ascon core, with length check, watchdog and optional tag compare.     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module ascon_aead_seq #(
  parameter int MAX_PT_BLOCKS = 23,
  parameter int MAX_AD_BLOCKS = 4,
  parameter int TIMEOUT_CYC   = 1024
) (
  input  logic                                 clock_i,
  input  logic                                 reset_i,
  input  logic                                 start_i,
  input  logic [$clog2(MAX_PT_BLOCKS+1)-1:0]   pt_len_i,
  input  logic [$clog2(MAX_AD_BLOCKS+1)-1:0]   ad_len_i,
  input  logic                                 check_tag_i,
  input  logic [64*MAX_PT_BLOCKS-1:0]          plain_text_i,
  input  logic [64*MAX_AD_BLOCKS-1:0]          ad_i,
  input  logic [127:0]                         key_i,
  input  logic [127:0]                         nonce_i,
  input  logic [127:0]                         exp_tag_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic [1:0]                           error_o,
  output logic [64*MAX_PT_BLOCKS-1:0]          cipher_o,
  output logic [127:0]                         tag_o,
  ascon_aead_seq_if.master                     core
);
  localparam int PW = $clog2(MAX_PT_BLOCKS+1);
  localparam int AW = $clog2(MAX_AD_BLOCKS+1);
  localparam int CW = (PW > AW) ? PW : AW;
  localparam int WW = $clog2(TIMEOUT_CYC+1);
  localparam logic [PW-1:0] c_max_pt    = PW'(MAX_PT_BLOCKS);
  localparam logic [AW-1:0] c_max_ad    = AW'(MAX_AD_BLOCKS);
  localparam logic [WW-1:0] c_wdog_last = WW'(TIMEOUT_CYC-1);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_WAIT_INIT, S_AD_LOAD, S_AD_WAIT,
    S_PT_LOAD, S_PT_WAIT, S_FINAL_WAIT, S_DONE
  } state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d, cnt_inc;
  logic [WW-1:0]               wdog_q, wdog_d;
  logic [PW-1:0]               pt_len_q, pt_len_d;
  logic [AW-1:0]               ad_len_q, ad_len_d;
  logic [127:0]                key_q, key_d, nonce_q, nonce_d, tag_q, tag_d;
  logic                        busy_q, busy_d, done_q, done_d;
  logic [1:0]                  error_q, error_d;
  logic [64*MAX_PT_BLOCKS-1:0] cipher_q, cipher_d;
  logic                        init_q, init_d, ad_q, ad_d, fin_q, fin_d, valid_q, valid_d;
  logic [63:0]                 data_q, data_d;
  logic                        in_wait;

  assign cnt_inc = cnt_q + CW'(1);
  assign in_wait = (state_q == S_WAIT_INIT) || (state_q == S_AD_WAIT) ||
                   (state_q == S_PT_WAIT)   || (state_q == S_FINAL_WAIT);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pt_len_d = pt_len_q;
    ad_len_d = ad_len_q;
    key_d    = key_q;
    nonce_d  = nonce_q;
    tag_d    = tag_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = error_q;
    cipher_d = cipher_q;
    init_d   = 1'b0;
    ad_d     = 1'b0;
    fin_d    = 1'b0;
    valid_d  = 1'b0;
    data_d   = data_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (pt_len_i == '0 || pt_len_i > c_max_pt || ad_len_i > c_max_ad) begin
            error_d = 2'd1;
            done_d  = 1'b1;
          end else begin
            pt_len_d = pt_len_i;
            ad_len_d = ad_len_i;
            key_d    = key_i;
            nonce_d  = nonce_i;
            cipher_d = '0;
            tag_d    = '0;
            error_d  = 2'd0;
            busy_d   = 1'b1;
            cnt_d    = '0;
            state_d  = S_INIT;
          end
        end
      end
      S_INIT: begin
        init_d  = 1'b1;
        state_d = S_WAIT_INIT;
      end
      S_WAIT_INIT: begin
        if (core.end_init) begin
          cnt_d   = '0;
          state_d = (ad_len_q != '0) ? S_AD_LOAD : S_PT_LOAD;
        end
      end
      S_AD_LOAD: begin
        ad_d    = 1'b1;
        valid_d = 1'b1;
        data_d  = ad_i[{cnt_q, 6'd0} +: 64];
        state_d = S_AD_WAIT;
      end
      S_AD_WAIT: begin
        if (core.end_ad) begin
          if (cnt_inc == CW'(ad_len_q)) begin
            cnt_d   = '0;
            state_d = S_PT_LOAD;
          end else begin
            cnt_d   = cnt_inc;
            state_d = S_AD_LOAD;
          end
        end
      end
      S_PT_LOAD: begin
        valid_d = 1'b1;
        data_d  = plain_text_i[{cnt_q, 6'd0} +: 64];
        if (cnt_inc == CW'(pt_len_q)) begin
          fin_d   = 1'b1;
          state_d = S_FINAL_WAIT;
        end else begin
          state_d = S_PT_WAIT;
        end
      end
      // Capture uses the pre-increment count, so a same-cycle end still lands in the right block
      S_PT_WAIT: begin
        if (core.cipher_valid) cipher_d[{cnt_q, 6'd0} +: 64] = core.cipher;
        if (core.end_cipher) begin
          cnt_d   = cnt_inc;
          state_d = S_PT_LOAD;
        end
      end
      S_FINAL_WAIT: begin
        if (core.cipher_valid) cipher_d[{cnt_q, 6'd0} +: 64] = core.cipher;
        if (core.end_tag) begin
          tag_d   = core.tag;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        if (check_tag_i && tag_q != exp_tag_i) error_d = 2'd3;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A response arriving on the last watchdog cycle wins over the timeout
    if (in_wait && state_d == state_q && wdog_q == c_wdog_last) begin
      error_d = 2'd2;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      state_d = S_IDLE;
    end

    wdog_d = (!in_wait || state_d != state_q) ? '0 : wdog_q + WW'(1);
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wdog_q   <= '0;
      pt_len_q <= '0;
      ad_len_q <= '0;
      key_q    <= '0;
      nonce_q  <= '0;
      tag_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 2'd0;
      cipher_q <= '0;
      init_q   <= 1'b0;
      ad_q     <= 1'b0;
      fin_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wdog_q   <= wdog_d;
      pt_len_q <= pt_len_d;
      ad_len_q <= ad_len_d;
      key_q    <= key_d;
      nonce_q  <= nonce_d;
      tag_q    <= tag_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      cipher_q <= cipher_d;
      init_q   <= init_d;
      ad_q     <= ad_d;
      fin_q    <= fin_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign error_o    = error_q;
  assign cipher_o   = cipher_q;
  assign tag_o      = tag_q;
  assign core.init  = init_q;
  assign core.ad    = ad_q;
  assign core.fin   = fin_q;
  assign core.valid = valid_q;
  assign core.data  = data_q;
  assign core.key   = key_q;
  assign core.nonce = nonce_q;
endmodule
`default_nettype wire

// File: tb/tb_ascon_aead_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ascon_aead_seq : vector table + random runs against a toy core     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_ascon_aead_seq;
  localparam int MPT = 23;
  localparam int MAD = 4;
  localparam int TO  = 128;
  localparam int PW  = $clog2(MPT+1);
  localparam int AW  = $clog2(MAD+1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 start = 1'b0;
  logic [PW-1:0]        pt_len = '0;
  logic [AW-1:0]        ad_len = '0;
  logic                 chk = 1'b0;
  logic [64*MPT-1:0]    pt = '0;
  logic [64*MAD-1:0]    ad = '0;
  logic [127:0]         key = '0, nonce = '0, exp_tag = '0;
  logic                 busy, done;
  logic [1:0]           err;
  logic [64*MPT-1:0]    cipher;
  logic [127:0]         tag;

  ascon_aead_seq_if core_if();

  ascon_aead_seq #(.MAX_PT_BLOCKS(MPT), .MAX_AD_BLOCKS(MAD), .TIMEOUT_CYC(TO)) dut (
    .clock_i(clk), .reset_i(rst_n), .start_i(start), .pt_len_i(pt_len), .ad_len_i(ad_len),
    .check_tag_i(chk), .plain_text_i(pt), .ad_i(ad), .key_i(key), .nonce_i(nonce),
    .exp_tag_i(exp_tag), .busy_o(busy), .done_o(done), .error_o(err), .cipher_o(cipher),
    .tag_o(tag), .core(core_if)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ks(input logic [127:0] k, input logic [127:0] n, input int i);
    return k[63:0] ^ n[127:64] ^ (64'h9E3779B97F4A7C15 * 64'(i + 1));
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] acc, input logic [127:0] w);
    return {acc[126:0], acc[127]} ^ w;
  endfunction

  // Toy core: fixed latency, keystream XOR, rotating-XOR tag
  typedef struct {int kind; logic [63:0] data; bit fin;} ev_t;
  ev_t          log_q[$];
  int           lat = 4;
  bit           split = 1'b0;
  int           drop_idx = -1;
  int           m_timer, m_kind, m_idx;
  logic [127:0] m_acc;
  logic [63:0]  m_ct;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_if.end_init <= 1'b0; core_if.end_ad <= 1'b0; core_if.cipher_valid <= 1'b0;
      core_if.end_cipher <= 1'b0; core_if.end_tag <= 1'b0;
      core_if.cipher <= '0; core_if.tag <= '0;
      m_timer <= 0; m_kind <= 0; m_idx <= 0; m_acc <= '0; m_ct <= '0;
    end else begin
      core_if.end_init <= 1'b0; core_if.end_ad <= 1'b0; core_if.cipher_valid <= 1'b0;
      core_if.end_cipher <= 1'b0; core_if.end_tag <= 1'b0;
      if (core_if.init) begin
        m_acc <= core_if.key ^ core_if.nonce; m_idx <= 0; m_kind <= 1; m_timer <= lat;
        log_q.push_back('{1, 64'h0, 1'b0});
      end else if (core_if.ad && core_if.valid) begin
        m_acc <= mix(m_acc, {64'h0, core_if.data}); m_kind <= 2; m_timer <= lat;
        log_q.push_back('{2, core_if.data, 1'b0});
      end else if (core_if.valid) begin
        m_ct  <= core_if.data ^ ks(core_if.key, core_if.nonce, m_idx);
        m_acc <= mix(m_acc, {core_if.data, 64'h0});
        m_kind <= core_if.fin ? 4 : 3; m_timer <= lat;
        log_q.push_back('{3, core_if.data, core_if.fin});
      end else if (m_timer > 0) begin
        m_timer <= m_timer - 1;
        if (m_timer == 2 && m_kind == 3 && split) begin
          core_if.cipher_valid <= 1'b1; core_if.cipher <= m_ct;
        end
        if (m_timer == 1) begin
          case (m_kind)
            1: core_if.end_init <= 1'b1;
            2: core_if.end_ad <= 1'b1;
            3: begin
              if (!split) begin core_if.cipher_valid <= 1'b1; core_if.cipher <= m_ct; end
              if (m_idx != drop_idx) core_if.end_cipher <= 1'b1;
              m_idx <= m_idx + 1;
            end
            4: begin
              core_if.cipher_valid <= 1'b1; core_if.cipher <= m_ct;
              core_if.end_tag <= 1'b1; core_if.tag <= m_acc;
            end
            default: ;
          endcase
        end
      end
    end
  end

  typedef struct {int pl; int al; bit c; bit flip; int drop; bit sp; int lat; int err;} vec_t;

  function automatic logic [127:0] enc(input ev_t e);
    return 128'({8'(e.kind), e.fin, e.data});
  endfunction

  task automatic run(input vec_t v, input string tname);
    logic [64*MPT-1:0] exp_c;
    logic [127:0]      exp_t, acc;
    ev_t               exp_log[$];
    int                dn, busy_bad, done_cyc, bad_k, bad_i, n;
    bit                seen;

    for (int i = 0; i < MPT; i++) pt[64*i +: 64] = {$urandom, $urandom};
    for (int i = 0; i < MAD; i++) ad[64*i +: 64] = {$urandom, $urandom};
    key   = {$urandom, $urandom, $urandom, $urandom};
    nonce = {$urandom, $urandom, $urandom, $urandom};
    lat = v.lat; split = v.sp; drop_idx = v.drop;

    // Expected results straight from the block arrays
    acc = key ^ nonce;
    for (int k = 0; k < v.al; k++) acc = mix(acc, {64'h0, ad[64*k +: 64]});
    for (int k = 0; k < v.pl; k++) acc = mix(acc, {pt[64*k +: 64], 64'h0});
    exp_t = (v.err == 2) ? 128'h0 : acc;
    exp_c = '0;
    for (int k = 0; k < v.pl; k++)
      if (v.drop < 0 || k <= v.drop) exp_c[64*k +: 64] = pt[64*k +: 64] ^ ks(key, nonce, k);
    if (v.err != 1) begin
      exp_log.push_back('{1, 64'h0, 1'b0});
      for (int k = 0; k < v.al; k++) exp_log.push_back('{2, ad[64*k +: 64], 1'b0});
      for (int k = 0; k < v.pl; k++)
        if (v.drop < 0 || k <= v.drop) exp_log.push_back('{3, pt[64*k +: 64], k == v.pl - 1});
    end
    chk = v.c;
    exp_tag = v.flip ? (acc ^ 128'h1) : acc;
    log_q.delete();

    @(negedge clk);
    pt_len = PW'(v.pl); ad_len = AW'(v.al); start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    dn = 0; busy_bad = 0; done_cyc = 0; seen = 1'b0;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      if (done) begin
        dn++;
        if (busy) busy_bad++;
        if (!seen) done_cyc = cyc;
        seen = 1'b1;
      end else if (!seen && ((v.err == 1) ? busy : !busy)) begin
        busy_bad++;
      end
      if (seen && cyc >= done_cyc + 3) break;
      @(negedge clk);
    end

    check({tname, " done pulses"}, 128'(dn), 128'(1));
    check({tname, " error"}, 128'(err), 128'(v.err));
    check({tname, " busy"}, 128'(busy_bad), 128'(0));
    check({tname, " strobe count"}, 128'(log_q.size()), 128'(exp_log.size()));
    n = (log_q.size() < exp_log.size()) ? log_q.size() : exp_log.size();
    if (n > 0) begin
      bad_i = 0;
      for (int i = n - 1; i >= 0; i--) if (enc(log_q[i]) !== enc(exp_log[i])) bad_i = i;
      check($sformatf("%s strobe %0d", tname, bad_i), enc(log_q[bad_i]), enc(exp_log[bad_i]));
    end
    if (v.err != 1) begin
      bad_k = 0;
      for (int k = MPT - 1; k >= 0; k--) if (cipher[64*k +: 64] !== exp_c[64*k +: 64]) bad_k = k;
      check($sformatf("%s cipher blk%0d", tname, bad_k), 128'(cipher[64*bad_k +: 64]),
            128'(exp_c[64*bad_k +: 64]));
      check({tname, " tag"}, tag, exp_t);
    end
    if (v.err == 2) begin
      check({tname, " timeout early"}, 128'(done_cyc >= TO), 128'(1));
      check({tname, " timeout late"}, 128'(done_cyc <= TO + 200), 128'(1));
    end
  endtask

  vec_t tbl[10];
  vec_t rv;
  int   wait_cyc;

  initial begin
    tbl[0] = '{3, 1, 0, 0, -1, 0, 4, 0};
    tbl[1] = '{1, 0, 0, 0, -1, 0, 4, 0};
    tbl[2] = '{0, 1, 0, 0, -1, 0, 4, 1};
    tbl[3] = '{MPT + 1, 0, 0, 0, -1, 0, 4, 1};
    tbl[4] = '{2, MAD + 1, 0, 0, -1, 0, 4, 1};
    tbl[5] = '{4, 2, 1, 1, -1, 0, 3, 3};
    tbl[6] = '{4, 2, 1, 0, -1, 0, 3, 0};
    tbl[7] = '{MPT, MAD, 0, 0, -1, 1, 2, 0};
    tbl[8] = '{5, 3, 0, 0, 1, 0, 4, 2};
    tbl[9] = '{2, 0, 1, 0, -1, 1, 5, 0};

    @(negedge clk);
    check("reset busy", 128'(busy), 128'(0));
    check("reset done", 128'(done), 128'(0));
    check("reset error", 128'(err), 128'(0));
    check("reset cipher", 128'(|cipher), 128'(0));
    check("reset tag", tag, 128'h0);
    check("reset strobes", 128'({core_if.init, core_if.ad, core_if.fin, core_if.valid}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

    for (int r = 0; r < 6; r++) begin
      rv.pl = $urandom_range(1, MPT); rv.al = $urandom_range(0, MAD);
      rv.c = 1'($urandom_range(0, 1)); rv.flip = 1'($urandom_range(0, 1));
      rv.drop = -1; rv.sp = 1'($urandom_range(0, 1)); rv.lat = $urandom_range(2, 6);
      rv.err = (rv.c && rv.flip) ? 3 : 0;
      run(rv, $sformatf("rnd%0d", r));
    end

    // Reset while waiting on the second plaintext block
    lat = 6; split = 1'b0; drop_idx = -1; chk = 1'b0;
    for (int i = 0; i < MPT; i++) pt[64*i +: 64] = {$urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
    log_q.delete();
    @(negedge clk);
    pt_len = PW'(3); ad_len = AW'(1); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc = 0;
    while (log_q.size() < 4 && wait_cyc < 500) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("midrst reached PT1", 128'(log_q.size()), 128'(4));
    @(negedge clk);
    check("midrst busy before", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    check("midrst busy", 128'(busy), 128'(0));
    check("midrst cipher", 128'(|cipher), 128'(0));
    check("midrst tag", tag, 128'h0);
    check("midrst error", 128'(err), 128'(0));
    check("midrst key", core_if.key, 128'h0);
    check("midrst strobes", 128'({core_if.init, core_if.ad, core_if.fin, core_if.valid}), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(tbl[0], "post-reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
